// File: rtl/mips_multicycle_ctrl.sv
// mips_multicycle_ctrl: multi-cycle MIPS main control FSM with a memory-ready handshake.
// Define CTRL_ILLEGAL_TRAP_EN to trap on illegal opcodes; otherwise they retire as NOPs.
module mips_multicycle_ctrl #(
    parameter int OPW = 6,
    parameter int ALUOPW = 2,
    parameter logic [OPW-1:0] OP_RTYPE = OPW'('h00),
    parameter logic [OPW-1:0] OP_LW = OPW'('h23),
    parameter logic [OPW-1:0] OP_SW = OPW'('h2B),
    parameter logic [OPW-1:0] OP_BEQ = OPW'('h04),
    parameter logic [OPW-1:0] OP_J = OPW'('h02),
    parameter logic [OPW-1:0] OP_ADDI = OPW'('h08),
    parameter logic [ALUOPW-1:0] ALUOP_ADD = ALUOPW'(0),
    parameter logic [ALUOPW-1:0] ALUOP_SUB = ALUOPW'(1),
    parameter logic [ALUOPW-1:0] ALUOP_FUNCT = ALUOPW'(2)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [OPW-1:0]    opcode,
    input  logic              mem_ready,
    output logic              pc_write,
    output logic              pc_write_cond,
    output logic              iord,
    output logic              mem_read,
    output logic              mem_write,
    output logic              ir_write,
    output logic              reg_dst,
    output logic              memto_reg,
    output logic              reg_write,
    output logic              alu_src_a,
    output logic [1:0]        alu_src_b,
    output logic [ALUOPW-1:0] alu_op,
    output logic [1:0]        pc_source,
    output logic              instr_done,
    output logic              illegal_op,
    output logic [3:0]        state
);
`ifdef CTRL_ILLEGAL_TRAP_EN
    localparam logic TRAP_EN = 1'b1;
`else
    localparam logic TRAP_EN = 1'b0;
`endif

    typedef enum logic [3:0] {
        FETCH = 4'd0, DECODE = 4'd1, MEMADR = 4'd2, MEMRD = 4'd3, MEMWB = 4'd4,
        MEMWR = 4'd5, EXEC = 4'd6, RWB = 4'd7, BRANCH = 4'd8, JUMP = 4'd9,
        ADDIEX = 4'd10, ADDIWB = 4'd11, TRAP = 4'd12
    } state_t;

    state_t cur, nxt;

    always_ff @(posedge clk)
        cur <= reset ? FETCH : nxt;

    assign state = reset ? 4'd0 : cur;

    always_comb begin
        nxt = cur;
        pc_write = 1'b0;
        pc_write_cond = 1'b0;
        iord = 1'b0;
        mem_read = 1'b0;
        mem_write = 1'b0;
        ir_write = 1'b0;
        reg_dst = 1'b0;
        memto_reg = 1'b0;
        reg_write = 1'b0;
        alu_src_a = 1'b0;
        alu_src_b = 2'b00;
        alu_op = ALUOP_ADD;
        pc_source = 2'b00;
        instr_done = 1'b0;
        illegal_op = 1'b0;
        case (cur)
            FETCH: begin
                mem_read = 1'b1;
                alu_src_b = 2'b01;
                ir_write = mem_ready;
                pc_write = mem_ready;
                nxt = mem_ready ? DECODE : FETCH;
            end
            DECODE: begin
                alu_src_b = 2'b11;
                nxt = (opcode == OP_LW || opcode == OP_SW) ? MEMADR :
                      (opcode == OP_RTYPE) ? EXEC :
                      (opcode == OP_BEQ) ? BRANCH :
                      (opcode == OP_J) ? JUMP :
                      (opcode == OP_ADDI) ? ADDIEX :
                      TRAP_EN ? TRAP : FETCH;
                // Without the trap build, an unknown opcode retires here as a NOP.
                instr_done = !TRAP_EN && nxt == FETCH;
            end
            MEMADR: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'b10;
                nxt = (opcode == OP_LW) ? MEMRD : (opcode == OP_SW) ? MEMWR : FETCH;
            end
            MEMRD: begin
                mem_read = 1'b1;
                iord = 1'b1;
                nxt = mem_ready ? MEMWB : MEMRD;
            end
            MEMWB: begin
                reg_write = 1'b1;
                memto_reg = 1'b1;
                instr_done = 1'b1;
                nxt = FETCH;
            end
            MEMWR: begin
                mem_write = 1'b1;
                iord = 1'b1;
                instr_done = mem_ready;
                nxt = mem_ready ? FETCH : MEMWR;
            end
            EXEC: begin
                alu_src_a = 1'b1;
                alu_op = ALUOP_FUNCT;
                nxt = RWB;
            end
            RWB: begin
                reg_write = 1'b1;
                reg_dst = 1'b1;
                instr_done = 1'b1;
                nxt = FETCH;
            end
            BRANCH: begin
                alu_src_a = 1'b1;
                alu_op = ALUOP_SUB;
                pc_write_cond = 1'b1;
                pc_source = 2'b01;
                instr_done = 1'b1;
                nxt = FETCH;
            end
            JUMP: begin
                pc_write = 1'b1;
                pc_source = 2'b10;
                instr_done = 1'b1;
                nxt = FETCH;
            end
            ADDIEX: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'b10;
                nxt = ADDIWB;
            end
            ADDIWB: begin
                reg_write = 1'b1;
                instr_done = 1'b1;
                nxt = FETCH;
            end
            TRAP: begin
                illegal_op = TRAP_EN;
                nxt = TRAP_EN ? TRAP : FETCH;
            end
            default: nxt = FETCH;
        endcase
        if (reset) begin
            pc_write = 1'b0;
            pc_write_cond = 1'b0;
            iord = 1'b0;
            mem_read = 1'b0;
            mem_write = 1'b0;
            ir_write = 1'b0;
            reg_dst = 1'b0;
            memto_reg = 1'b0;
            reg_write = 1'b0;
            alu_src_a = 1'b0;
            alu_src_b = 2'b00;
            alu_op = '0;
            pc_source = 2'b00;
            instr_done = 1'b0;
            illegal_op = 1'b0;
        end
    end
endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
// tb_mips_multicycle_ctrl: directed checks of the multi-cycle control FSM sequencing and outputs.
module tb_mips_multicycle_ctrl;
    logic clk = 1'b0;
    logic reset = 1'b1;
    logic [5:0] opcode = 6'h00;
    logic mem_ready = 1'b1;
    logic pc_write, pc_write_cond, iord, mem_read, mem_write, ir_write;
    logic reg_dst, memto_reg, reg_write, alu_src_a, instr_done, illegal_op;
    logic [1:0] alu_src_b, alu_op, pc_source;
    logic [3:0] state;
    int n_checks = 0;
    int n_fail = 0;

    mips_multicycle_ctrl dut (
        .clk(clk), .reset(reset), .opcode(opcode), .mem_ready(mem_ready),
        .pc_write(pc_write), .pc_write_cond(pc_write_cond), .iord(iord),
        .mem_read(mem_read), .mem_write(mem_write), .ir_write(ir_write),
        .reg_dst(reg_dst), .memto_reg(memto_reg), .reg_write(reg_write),
        .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_op(alu_op),
        .pc_source(pc_source), .instr_done(instr_done), .illegal_op(illegal_op),
        .state(state)
    );

    always #5 clk = ~clk;

    wire [23:0] all_out = {pc_write, pc_write_cond, iord, mem_read, mem_write, ir_write,
                           reg_dst, memto_reg, reg_write, alu_src_a, alu_src_b, alu_op,
                           pc_source, instr_done, illegal_op, state};

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic run(input string tag, input logic [5:0] op, input logic [3:0] stall_st,
                       input int stalls, input int exp_cyc, input logic [15:0] exp_vis,
                       output int wr_cyc);
        int cyc = 0;
        int left = stalls;
        int bad = 0;
        logic [15:0] vis = '0;
        logic done = 1'b0;
        wr_cyc = 0;
        opcode = op;
        while (!done && cyc < 30) begin
            mem_ready = !(state == stall_st && left > 0);
            if (!mem_ready) left--;
            #1;
            vis[state] = 1'b1;
            cyc++;
            if (mem_read && mem_write) bad++;
            if (reg_write && !(state inside {4'd4, 4'd7, 4'd11})) bad++;
            case (state)
                4'd0: check({tag, " fetch ir_write"}, {ir_write, pc_write}, {2{mem_ready}});
                4'd3: check({tag, " memrd"}, {mem_read, iord}, 2'b11);
                4'd4: check({tag, " memwb"}, {reg_write, memto_reg, reg_dst}, 3'b110);
                4'd5: begin
                    check({tag, " memwr"}, {mem_write, iord, instr_done}, {2'b11, mem_ready});
                    wr_cyc++;
                end
                4'd6: check({tag, " exec alu_op"}, alu_op, 2'b10);
                4'd7: check({tag, " rwb"}, {reg_write, reg_dst, memto_reg}, 3'b110);
                4'd8: check({tag, " branch"}, {alu_op, pc_write_cond, pc_source, pc_write}, 6'b01_1_01_0);
                4'd9: check({tag, " jump"}, {pc_write, pc_source}, 3'b1_10);
                4'd10: check({tag, " addiex"}, {alu_src_a, alu_src_b, reg_write}, 4'b1_10_0);
                4'd11: check({tag, " addiwb"}, {reg_write, reg_dst, memto_reg}, 3'b100);
                default: ;
            endcase
            done = instr_done;
            @(posedge clk);
            #1;
        end
        mem_ready = 1'b1;
        check({tag, " cycles"}, cyc, exp_cyc);
        check({tag, " states"}, vis, exp_vis);
        check({tag, " rules"}, bad, 0);
        check({tag, " back to fetch"}, state, 4'd0);
    endtask

    initial begin
        int wr;
        tick();
        tick();
        check("reset outputs", all_out, 24'h0);
        check("reset state", state, 4'd0);
        reset = 1'b0;
        #1;
        check("first fetch", {mem_read, ir_write, pc_write, iord}, 4'b1110);
        check("first fetch state", state, 4'd0);
        run("lw", 6'h23, 4'd15, 0, 5, 16'h001F, wr);
        run("sw", 6'h2B, 4'd5, 3, 7, 16'h0027, wr);
        check("sw mem_write cycles", wr, 4);
        run("rtype", 6'h00, 4'd15, 0, 4, 16'h00C3, wr);
        run("beq", 6'h04, 4'd0, 2, 5, 16'h0103, wr);
        run("j", 6'h02, 4'd15, 0, 3, 16'h0203, wr);
        run("addi", 6'h08, 4'd15, 0, 4, 16'h0C03, wr);
        run("lw stall", 6'h23, 4'd3, 2, 7, 16'h001F, wr);
        opcode = 6'h08;
        tick();
        tick();
        check("addi mid state", state, 4'd10);
        reset = 1'b1;
        #1;
        check("mid reset outputs", all_out, 24'h0);
        tick();
        reset = 1'b0;
        #1;
        check("after abort state", state, 4'd0);
        check("after abort reg_write", reg_write, 1'b0);
        opcode = 6'h3F;
        tick();
        check("illegal decode state", state, 4'd1);
`ifdef CTRL_ILLEGAL_TRAP_EN
        check("illegal decode done", instr_done, 1'b0);
        tick();
        check("trap entry", {state, illegal_op, mem_read, instr_done}, {4'd12, 3'b100});
        opcode = 6'h00;
        repeat (3) tick();
        check("trap held", {state, illegal_op, instr_done, pc_write}, {4'd12, 3'b100});
        reset = 1'b1;
        tick();
        reset = 1'b0;
        #1;
        check("trap cleared", {state, illegal_op}, 5'd0);
`else
        check("illegal nop", {instr_done, illegal_op, reg_write, mem_write}, 4'b1000);
        tick();
        check("illegal back to fetch", {state, illegal_op}, 5'd0);
        run("after nop rtype", 6'h00, 4'd15, 0, 4, 16'h00C3, wr);
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
